// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl_unit                                            |
// | Description : Load-use hazard detector with multi-cycle stall FSM, flush  |
// |               and memory-wait freeze arbitration, saturating stall count. |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module hazard_ctrl_unit #(
    parameter int REG_AW     = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_STALL = 1,
    parameter int POP_EXEMPT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC*REG_AW-1:0] src_dec,
    input  logic [NSRC-1:0]        src_vld_dec,
    input  logic [REG_AW-1:0]      rd_ex,
    input  logic                   mem_read_ex,
    input  logic                   pop_ex,
    input  logic                   flush_req,
    input  logic                   mem_wait,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   pipe_freeze,
    output logic                   stall_busy,
    output logic [15:0]            stall_total
);

    localparam logic [0:0] c_st_run      = 1'b0;
    localparam logic [0:0] c_st_stall    = 1'b1;
    localparam logic       c_multi       = (LOAD_STALL > 1);
    localparam logic [3:0] c_remain_init = (LOAD_STALL > 1) ? 4'(LOAD_STALL - 2) : 4'd0;
    localparam logic       c_pop_exempt  = (POP_EXEMPT != 0);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [3:0]      r_remain;
    logic [3:0]      w_remain_nxt;
    logic [15:0]     r_total;
    logic [15:0]     w_total_nxt;
    logic [15:0]     w_total_inc;
    logic [NSRC-1:0] w_hit;
    logic            w_hazard;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_hit[gi] = src_vld_dec[gi]
                             & (src_dec[gi*REG_AW +: REG_AW] == rd_ex)
                             & mem_read_ex
                             & ~(c_pop_exempt & pop_ex);
        end
    endgenerate

    assign w_hazard    = |w_hit;
    assign w_total_inc = (r_total == 16'hFFFF) ? r_total : r_total + 16'd1;
    assign stall_total = r_total;

    // Priority: rst > mem_wait > flush_req > STALL > hazard in RUN > normal.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_freeze  = 1'b0;
        stall_busy   = (r_state == c_st_stall) & ~rst;
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_total_nxt  = r_total;
        if (!rst) begin
            if (mem_wait) begin
                pipe_freeze = 1'b1;
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
            end else if (flush_req) begin
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                w_state_nxt  = c_st_run;
                w_remain_nxt = 4'd0;
            end else if (r_state == c_st_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                w_total_nxt = w_total_inc;
                if (r_remain == 4'd0) begin
                    w_state_nxt = c_st_run;
                end else begin
                    w_remain_nxt = r_remain - 4'd1;
                end
            end else if (w_hazard) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                w_total_nxt = w_total_inc;
                // The first bubble is this cycle; STALL covers the remainder.
                if (c_multi) begin
                    w_state_nxt  = c_st_stall;
                    w_remain_nxt = c_remain_init;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_run;
            r_remain <= 4'd0;
            r_total  <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
            r_total  <= w_total_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl_unit                                         |
// | Description : Directed self-checking bench for hazard_ctrl_unit with      |
// |               LOAD_STALL = 1, 3 and 4 instances sharing one stimulus.     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl_unit;

    // Control vector order: {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze, stall_busy}
    localparam logic [5:0] c_norm     = 6'b110000;
    localparam logic [5:0] c_bub_run  = 6'b000100;
    localparam logic [5:0] c_bub_stl  = 6'b000101;
    localparam logic [5:0] c_flush    = 6'b111100;
    localparam logic [5:0] c_flush_st = 6'b111101;
    localparam logic [5:0] c_frz_run  = 6'b000010;
    localparam logic [5:0] c_frz_stl  = 6'b000011;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] src_dec;
    logic [1:0] src_vld_dec;
    logic [2:0] rd_ex;
    logic       mem_read_ex;
    logic       pop_ex;
    logic       flush_req;
    logic       mem_wait;

    logic [5:0]  ctl1, ctl3, ctl4;
    logic [15:0] tot1, tot3, tot4;

    int cnt_total = 0;
    int cnt_bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LOAD_STALL(1)) u_ls1 (
        .clk(clk), .rst(rst), .src_dec(src_dec), .src_vld_dec(src_vld_dec),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .pop_ex(pop_ex),
        .flush_req(flush_req), .mem_wait(mem_wait),
        .pc_en(ctl1[5]), .ifid_en(ctl1[4]), .ifid_flush(ctl1[3]),
        .idex_bubble(ctl1[2]), .pipe_freeze(ctl1[1]), .stall_busy(ctl1[0]),
        .stall_total(tot1)
    );

    hazard_ctrl_unit #(.LOAD_STALL(3)) u_ls3 (
        .clk(clk), .rst(rst), .src_dec(src_dec), .src_vld_dec(src_vld_dec),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .pop_ex(pop_ex),
        .flush_req(flush_req), .mem_wait(mem_wait),
        .pc_en(ctl3[5]), .ifid_en(ctl3[4]), .ifid_flush(ctl3[3]),
        .idex_bubble(ctl3[2]), .pipe_freeze(ctl3[1]), .stall_busy(ctl3[0]),
        .stall_total(tot3)
    );

    hazard_ctrl_unit #(.LOAD_STALL(4)) u_ls4 (
        .clk(clk), .rst(rst), .src_dec(src_dec), .src_vld_dec(src_vld_dec),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .pop_ex(pop_ex),
        .flush_req(flush_req), .mem_wait(mem_wait),
        .pc_en(ctl4[5]), .ifid_en(ctl4[4]), .ifid_flush(ctl4[3]),
        .idex_bubble(ctl4[2]), .pipe_freeze(ctl4[1]), .stall_busy(ctl4[0]),
        .stall_total(tot4)
    );

    task automatic chk_ctl(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        cnt_total++;
        assert (obs === exp) else begin
            cnt_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cnt_total++;
        assert (obs === exp) else begin
            cnt_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        src_dec = 6'd0; src_vld_dec = 2'b00; rd_ex = 3'd0; mem_read_ex = 1'b0;
        pop_ex = 1'b0; flush_req = 1'b0; mem_wait = 1'b0;
    endtask

    // Load to r3 in EX, decode operand 1 reads r3.
    task automatic set_hazard();
        set_idle();
        src_dec = {3'd3, 3'd0}; src_vld_dec = 2'b10; rd_ex = 3'd3; mem_read_ex = 1'b1;
    endtask

    // Advance to the next cycle's input window.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(); set_idle(); rst = 1'b1;
        cyc(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();

        // Reset with a live hazard on the inputs: outputs must stay at defaults.
        cyc(); set_hazard(); rst = 1'b1; #1;
        chk_ctl("rst_outputs_ls1", ctl1, c_norm);
        chk_ctl("rst_outputs_ls3", ctl3, c_norm);
        cyc(); #1;
        chk_cnt("rst_total_ls3", tot3, 16'd0);

        // LOAD_STALL=1: single bubble on operand-1 hit.
        do_reset(); set_hazard(); #1;
        chk_ctl("ls1_hazard_bubble", ctl1, c_bub_run);
        cyc(); set_idle(); #1;
        chk_ctl("ls1_after_hazard", ctl1, c_norm);
        chk_cnt("ls1_total_1", tot1, 16'd1);

        cyc(); set_hazard(); pop_ex = 1'b1; #1;
        chk_ctl("ls1_pop_exempt", ctl1, c_norm);
        cyc(); set_hazard(); src_vld_dec = 2'b00; #1;
        chk_ctl("ls1_src_invalid", ctl1, c_norm);
        cyc(); set_hazard(); mem_read_ex = 1'b0; #1;
        chk_ctl("ls1_not_load", ctl1, c_norm);
        cyc(); set_hazard(); rd_ex = 3'd4; #1;
        chk_ctl("ls1_addr_miss", ctl1, c_norm);
        cyc(); set_idle(); src_dec = {3'd0, 3'd5}; src_vld_dec = 2'b01;
        rd_ex = 3'd5; mem_read_ex = 1'b1; #1;
        chk_ctl("ls1_operand0_hit", ctl1, c_bub_run);
        cyc(); set_idle(); #1;
        chk_cnt("ls1_total_2", tot1, 16'd2);

        // LOAD_STALL=3: three bubbles, busy on bubbles 2 and 3.
        do_reset(); set_hazard(); #1;
        chk_ctl("ls3_bub1", ctl3, c_bub_run);
        cyc(); set_idle(); #1;
        chk_ctl("ls3_bub2", ctl3, c_bub_stl);
        cyc(); #1;
        chk_ctl("ls3_bub3", ctl3, c_bub_stl);
        cyc(); #1;
        chk_ctl("ls3_run_again", ctl3, c_norm);
        chk_cnt("ls3_total_3", tot3, 16'd3);

        // LOAD_STALL=3 with a two-cycle freeze in stall cycle 2.
        do_reset(); set_hazard(); #1;
        chk_ctl("ls3w_bub1", ctl3, c_bub_run);
        cyc(); set_idle(); mem_wait = 1'b1; #1;
        chk_ctl("ls3w_frz1", ctl3, c_frz_stl);
        cyc(); #1;
        chk_ctl("ls3w_frz2", ctl3, c_frz_stl);
        cyc(); mem_wait = 1'b0; #1;
        chk_ctl("ls3w_bub2", ctl3, c_bub_stl);
        chk_cnt("ls3w_total_frozen", tot3, 16'd1);
        cyc(); #1;
        chk_ctl("ls3w_bub3", ctl3, c_bub_stl);
        cyc(); #1;
        chk_ctl("ls3w_run_again", ctl3, c_norm);
        chk_cnt("ls3w_total_3", tot3, 16'd3);

        // LOAD_STALL=4: flush in stall cycle 2 aborts the stall.
        do_reset(); set_hazard(); #1;
        chk_ctl("ls4_bub1", ctl4, c_bub_run);
        cyc(); set_idle(); flush_req = 1'b1; #1;
        chk_ctl("ls4_flush_in_stall", ctl4, c_flush_st);
        cyc(); set_idle(); #1;
        chk_ctl("ls4_run_after_flush", ctl4, c_norm);
        chk_cnt("ls4_total_1", tot4, 16'd1);

        // Hazard and flush together: flush wins, nothing counted.
        do_reset(); set_hazard(); flush_req = 1'b1; #1;
        chk_ctl("hz_flush_ls1", ctl1, c_flush);
        chk_ctl("hz_flush_ls3", ctl3, c_flush);
        cyc(); set_idle(); #1;
        chk_ctl("hz_flush_ls3_next", ctl3, c_norm);
        chk_cnt("hz_flush_total", tot3, 16'd0);

        // mem_wait and flush together: freeze only.
        cyc(); set_hazard(); flush_req = 1'b1; mem_wait = 1'b1; #1;
        chk_ctl("wait_flush_ls3", ctl3, c_frz_run);
        cyc(); set_idle(); #1;
        chk_cnt("wait_flush_total", tot3, 16'd0);

        // Reset in stall cycle 2.
        do_reset(); set_hazard(); #1;
        chk_ctl("rst_mid_bub1", ctl3, c_bub_run);
        cyc(); set_idle(); rst = 1'b1; #1;
        chk_ctl("rst_mid_outputs", ctl3, c_norm);
        cyc(); rst = 1'b0; #1;
        chk_ctl("rst_mid_after", ctl3, c_norm);
        chk_cnt("rst_mid_total", tot3, 16'd0);

        // Long hazard run drives the counter into saturation.
        do_reset(); set_hazard();
        repeat (65534) @(posedge clk);
        #1;
        chk_cnt("sat_pre_ls1", tot1, 16'hFFFE);
        @(posedge clk); #1;
        chk_cnt("sat_hit_ls1", tot1, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk_cnt("sat_hold_ls1", tot1, 16'hFFFF);
        chk_cnt("sat_hold_ls3", tot3, 16'hFFFF);
        chk_ctl("sat_still_bubble", ctl1, c_bub_run);

        cyc(); set_idle();
        $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
        $finish;
    end

endmodule
`default_nettype wire
